// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and constants for the memory-port arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [31:0] MEM_WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-bus signal bundle for the arbiter
interface mem_arbiter_if;

    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic [31:0] fetch_rdata;
    logic        data_valid;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_ready;
    logic [31:0] data_rdata;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        timeout;

    modport slave (
        input  fetch_valid, fetch_addr, data_valid, data_addr, data_wdata, data_wstrb,
        input  mem_ready, mem_rdata,
        output fetch_ready, fetch_rdata, data_ready, data_rdata,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, timeout
    );

    modport master (
        output fetch_valid, fetch_addr, data_valid, data_addr, data_wdata, data_wstrb,
        output mem_ready, mem_rdata,
        input  fetch_ready, fetch_rdata, data_ready, data_rdata,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, timeout
    );

endinterface

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - bus stall counter, only built with MEM_ARBITER_TIMEOUT_EN
module mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic stall_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 16'd0;
        end else if (stall_i) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single picorv32-style memory port
// Optional bus watchdog enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    arb_state_t  state_q, state_d;
    logic        last_data_q, last_data_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        fetch_ready_d, data_ready_d;
    logic [31:0] fetch_rdata_d, data_rdata_d;
    logic        on_bus_d;
    logic        expired, blocked;

    logic        fetch_ready_q, data_ready_q, mem_valid_q, mem_instr_q;
    logic [31:0] fetch_rdata_q, data_rdata_q, mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_wstrb_q;

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic timeout_q, grant, stall;

    assign grant = (state_q == IDLE) && !timeout_q && (bus.data_valid || bus.fetch_valid);
    assign stall = ((state_q == FETCH) || (state_q == DATA)) && !bus.mem_ready;

    mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (grant),
        .stall_i   (stall),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_q | (stall && expired);
        end
    end

    assign blocked     = timeout_q;
    assign bus.timeout = timeout_q;
`else
    assign expired     = 1'b0;
    assign blocked     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        last_data_d   = last_data_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        fetch_ready_d = 1'b0;
        data_ready_d  = 1'b0;
        fetch_rdata_d = 32'd0;
        data_rdata_d  = 32'd0;
        case (state_q)
            IDLE: begin
                // On a tie, data wins unless it also won the previous grant.
                if (!blocked && bus.data_valid && (!bus.fetch_valid || !last_data_q)) begin
                    state_d = DATA;
                    addr_d  = bus.data_addr;
                    wdata_d = bus.data_wdata;
                    wstrb_d = bus.data_wstrb;
                end else if (!blocked && bus.fetch_valid) begin
                    state_d = FETCH;
                    addr_d  = bus.fetch_addr;
                    wdata_d = 32'd0;
                    wstrb_d = 4'd0;
                end
            end
            FETCH, DATA: begin
                if (bus.mem_ready) begin
                    state_d     = RESP;
                    last_data_d = (state_q == DATA);
                    if (state_q == DATA) begin
                        data_ready_d = 1'b1;
                        data_rdata_d = (wstrb_q == 4'd0) ? bus.mem_rdata : 32'd0;
                    end else begin
                        fetch_ready_d = 1'b1;
                        fetch_rdata_d = bus.mem_rdata;
                    end
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        on_bus_d = (state_d == FETCH) || (state_d == DATA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_data_q   <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            wstrb_q       <= 4'd0;
            fetch_ready_q <= 1'b0;
            data_ready_q  <= 1'b0;
            fetch_rdata_q <= 32'd0;
            data_rdata_q  <= 32'd0;
            mem_valid_q   <= 1'b0;
            mem_instr_q   <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wdata_q   <= 32'd0;
            mem_wstrb_q   <= 4'd0;
        end else begin
            state_q       <= state_d;
            last_data_q   <= last_data_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            fetch_ready_q <= fetch_ready_d;
            data_ready_q  <= data_ready_d;
            fetch_rdata_q <= fetch_rdata_d;
            data_rdata_q  <= data_rdata_d;
            mem_valid_q   <= on_bus_d;
            mem_instr_q   <= (state_d == FETCH);
            mem_addr_q    <= on_bus_d ? (addr_d & MEM_WORD_MASK) : 32'd0;
            mem_wdata_q   <= (state_d == DATA) ? wdata_d : 32'd0;
            mem_wstrb_q   <= (state_d == DATA) ? wstrb_d : 4'd0;
        end
    end

    assign bus.fetch_ready = fetch_ready_q;
    assign bus.fetch_rdata = fetch_rdata_q;
    assign bus.data_ready  = data_ready_q;
    assign bus.data_rdata  = data_rdata_q;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_instr   = mem_instr_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_wstrb   = mem_wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_valid"}, 32'(bus.mem_valid), 32'd0);
        chk({tag, " mem_instr"}, 32'(bus.mem_instr), 32'd0);
        chk({tag, " mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, " mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
        chk({tag, " fetch_ready"}, 32'(bus.fetch_ready), 32'd0);
        chk({tag, " fetch_rdata"}, bus.fetch_rdata, 32'd0);
        chk({tag, " data_ready"}, 32'(bus.data_ready), 32'd0);
        chk({tag, " data_rdata"}, bus.data_rdata, 32'd0);
        chk({tag, " timeout"}, 32'(bus.timeout), 32'd0);
    endtask

    initial begin
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = 32'd0;
        bus.data_valid  = 1'b0;
        bus.data_addr   = 32'd0;
        bus.data_wdata  = 32'd0;
        bus.data_wstrb  = 4'd0;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = 32'd0;

        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;

        // Fetch at 0x103 on a zero-wait bus
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'h0000_0103;
        tick();
        chk("f1 mem_valid", 32'(bus.mem_valid), 32'd1);
        chk("f1 mem_addr", bus.mem_addr, 32'h0000_0100);
        chk("f1 mem_instr", 32'(bus.mem_instr), 32'd1);
        chk("f1 mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("f1 fetch_ready", 32'(bus.fetch_ready), 32'd0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0013;
        tick();
        chk("f2 fetch_ready", 32'(bus.fetch_ready), 32'd1);
        chk("f2 fetch_rdata", bus.fetch_rdata, 32'h0000_0013);
        chk("f2 mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("f2 data_ready", 32'(bus.data_ready), 32'd0);
        bus.fetch_valid = 1'b0;
        bus.mem_ready   = 1'b0;
        tick();
        chk("f3 fetch_ready", 32'(bus.fetch_ready), 32'd0);
        chk("f3 mem_valid", 32'(bus.mem_valid), 32'd0);

        // Store with three wait cycles
        bus.data_valid = 1'b1;
        bus.data_addr  = 32'h0000_2000;
        bus.data_wdata = 32'hDEAD_BEEF;
        bus.data_wstrb = 4'b0011;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("st mem_valid", 32'(bus.mem_valid), 32'd1);
            chk("st mem_instr", 32'(bus.mem_instr), 32'd0);
            chk("st mem_addr", bus.mem_addr, 32'h0000_2000);
            chk("st mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("st mem_wstrb", 32'(bus.mem_wstrb), 32'h3);
            chk("st data_ready early", 32'(bus.data_ready), 32'd0);
            if (i == 3) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'h1234_5678;
            end
            tick();
        end
        chk("st data_ready", 32'(bus.data_ready), 32'd1);
        chk("st data_rdata", bus.data_rdata, 32'd0);
        chk("st mem_valid drop", 32'(bus.mem_valid), 32'd0);
        bus.data_valid = 1'b0;
        bus.mem_ready  = 1'b0;
        tick();
        chk("st data_ready single", 32'(bus.data_ready), 32'd0);

        // Both requesters continuously valid after reset, zero-wait bus
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'h0000_0040;
        bus.data_valid  = 1'b1;
        bus.data_addr   = 32'h0000_0080;
        bus.data_wstrb  = 4'd0;
        bus.mem_ready   = 1'b1;
        bus.mem_rdata   = 32'hA5A5_0000;
        for (int c = 1; c <= 12; c++) begin
            logic is_fetch;
            int   phase;
            tick();
            phase    = (c - 1) % 3;
            is_fetch = (((c - 1) / 3) % 2) == 1;
            chk("rr mem_valid", 32'(bus.mem_valid), (phase == 0) ? 32'd1 : 32'd0);
            chk("rr mem_instr", 32'(bus.mem_instr), (phase == 0 && is_fetch) ? 32'd1 : 32'd0);
            if (phase == 0) begin
                chk("rr mem_addr", bus.mem_addr, is_fetch ? 32'h0000_0040 : 32'h0000_0080);
            end
            chk("rr fetch_ready", 32'(bus.fetch_ready), (phase == 1 && is_fetch) ? 32'd1 : 32'd0);
            chk("rr data_ready", 32'(bus.data_ready), (phase == 1 && !is_fetch) ? 32'd1 : 32'd0);
            if (phase == 1) begin
                chk("rr rdata", is_fetch ? bus.fetch_rdata : bus.data_rdata, 32'hA5A5_0000);
            end
        end
        bus.fetch_valid = 1'b0;
        bus.data_valid  = 1'b0;
        bus.mem_ready   = 1'b0;
        tick();
        tick();

        // Reset while a fetch is stalled on the bus
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'h0000_0200;
        tick();
        tick();
        chk("rst pre mem_valid", 32'(bus.mem_valid), 32'd1);
        reset           = 1'b1;
        bus.fetch_valid = 1'b0;
        tick();
        chk_all_zero("rst mid");
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("rst late fetch_ready", 32'(bus.fetch_ready), 32'd0);
        chk("rst late mem_valid", 32'(bus.mem_valid), 32'd0);
        bus.mem_ready = 1'b0;
        tick();
        chk("rst late2 fetch_ready", 32'(bus.fetch_ready), 32'd0);
        chk("rst late2 data_ready", 32'(bus.data_ready), 32'd0);

`ifdef MEM_ARBITER_TIMEOUT_EN
        begin
            int  vcycles;
            bit  seen;
            vcycles = 0;
            seen    = 1'b0;
            bus.fetch_valid = 1'b1;
            bus.fetch_addr  = 32'h0000_0300;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                if (bus.mem_valid) vcycles++;
                if (bus.timeout) seen = 1'b1;
            end
            chk("to flag", 32'(seen), 32'd1);
            chk("to mem_valid", 32'(bus.mem_valid), 32'd0);
            chk("to stall cycles", 32'(vcycles), 32'd9);
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("to no grant", 32'(bus.mem_valid), 32'd0);
                chk("to no ready", 32'(bus.fetch_ready), 32'd0);
            end
            bus.fetch_valid = 1'b0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("to cleared", 32'(bus.timeout), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
